// File: rtl/score_display_n.sv
// score_display_n: N-digit BCD score and high-score keeper with a VGA digit-row overlay.
// Latency: score/hi update one clk after the triggering input; score_on lags x/y by exactly 1 clk.
// Backpressure: none; the pixel stream is free-running and every cycle is consumed.
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   x, y              current VGA pixel coordinate
//   enemy_hit         level input; each rising edge adds INC points
//   score_clr         synchronous clear of the current score (new game)
//   game_over         one-cycle pulse; commits score to high score if greater
//   show_hi           selects the rendered value: 0 = score, 1 = high score
//   score_bcd, hi_bcd packed BCD values, digit 0 in bits [3:0]
//   new_hi            the most recent game_over raised the high score
//   score_on          current (delayed) pixel is a lit glyph pixel
module score_display_n #(
    parameter int NUM_DIGITS = 4,
    parameter int X_LEFT     = 288,
    parameter int Y_TOP      = 16,
    parameter int DIGIT_W    = 16,
    parameter int DIGIT_H    = 16,
    parameter int INC        = 10,
    parameter int LZ_BLANK   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    enemy_hit,
    input  logic                    score_clr,
    input  logic                    game_over,
    input  logic                    show_hi,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] hi_bcd,
    output logic                    new_hi,
    output logic                    score_on
);

    localparam int SW    = 4 * NUM_DIGITS;
    localparam int COL_W = $clog2(DIGIT_W);
    localparam int DY_W  = $clog2(DIGIT_H);
    localparam int ROW_W = $clog2(10 * DIGIT_H);

    // INC split into BCD tens/units digits at elaboration time.
    localparam logic [3:0]    INC_U = 4'(INC % 10);
    localparam logic [3:0]    INC_T = 4'(INC / 10);
    localparam logic [SW-1:0] ALL9  = {NUM_DIGITS{4'h9}};

    // Window bounds carried with one spare bit so X_LEFT+width never wraps.
    localparam logic [10:0] X_LO = 11'(X_LEFT);
    localparam logic [10:0] X_HI = 11'(X_LEFT + NUM_DIGITS * DIGIT_W);
    localparam logic [10:0] Y_LO = 11'(Y_TOP);
    localparam logic [10:0] Y_HI = 11'(Y_TOP + DIGIT_H);

    localparam bit               W_POW2 = ((DIGIT_W & (DIGIT_W - 1)) == 0);
    localparam logic [9:0]       DW10   = 10'(DIGIT_W);
    localparam logic [ROW_W-1:0] DH_R   = ROW_W'(DIGIT_H);

    // Glyph geometry: a seven-segment style font scaled to the cell size.
    localparam int SEG_T0 = DIGIT_H / 16;
    localparam int SEG_T1 = SEG_T0 + DIGIT_H / 8 - 1;
    localparam int SEG_M0 = DIGIT_H / 2 - 1;
    localparam int SEG_M1 = DIGIT_H / 2;
    localparam int SEG_B1 = DIGIT_H - DIGIT_H / 16 - 1;
    localparam int SEG_B0 = SEG_B1 - DIGIT_H / 8 + 1;
    localparam int SEG_L0 = DIGIT_W / 4 - 1;
    localparam int SEG_L1 = SEG_L0 + DIGIT_W / 8 - 1;
    localparam int SEG_R1 = DIGIT_W - DIGIT_W / 4;
    localparam int SEG_R0 = SEG_R1 - DIGIT_W / 8 + 1;

    // ------------------------------------------------------------------
    // Score state
    // ------------------------------------------------------------------
    logic          hit_q;
    logic          hit_pulse;
    logic [SW-1:0] score_q, score_d;
    logic [SW-1:0] hi_q, hi_d;
    logic          new_hi_q, new_hi_d;
    logic [SW-1:0] sum_bcd;
    logic          sum_ovf;

    assign hit_pulse = enemy_hit & ~hit_q;

    // One-cycle BCD ripple add of INC. A carry out of the top digit means
    // the result does not fit, which the update logic turns into all 9s.
    always_comb begin : p_bcd_add
        logic [4:0] dsum;
        logic [3:0] addend;
        logic       cy;
        sum_bcd = '0;
        dsum    = '0;
        addend  = '0;
        cy      = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            addend = (i == 0) ? INC_U : ((i == 1) ? INC_T : 4'd0);
            dsum   = {1'b0, score_q[4*i +: 4]} + {1'b0, addend} + {4'd0, cy};
            if (dsum > 5'd9) begin
                sum_bcd[4*i +: 4] = 4'(dsum - 5'd10);
                cy                = 1'b1;
            end else begin
                sum_bcd[4*i +: 4] = dsum[3:0];
                cy                = 1'b0;
            end
        end
        // With a single digit, a nonzero tens part of INC can never fit.
        sum_ovf = cy | ((NUM_DIGITS == 1) && (INC_T != 4'd0));
    end

    always_comb begin : p_score_next
        score_d  = score_q;
        hi_d     = hi_q;
        new_hi_d = new_hi_q;

        // Clear wins over a hit in the same cycle.
        if (score_clr) begin
            score_d = '0;
        end else if (hit_pulse) begin
            score_d = sum_ovf ? ALL9 : sum_bcd;
        end

        // Packed BCD digits are each <= 9, so a plain unsigned compare of
        // the vectors orders them exactly like an MSD-first digit compare.
        // The compare deliberately uses the pre-update score.
        if (game_over) begin
            if (score_q > hi_q) begin
                hi_d     = score_q;
                new_hi_d = 1'b1;
            end else begin
                new_hi_d = 1'b0;
            end
        end else if (score_clr) begin
            new_hi_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q    <= 1'b0;
            score_q  <= '0;
            hi_q     <= '0;
            new_hi_q <= 1'b0;
        end else begin
            hit_q    <= enemy_hit;
            score_q  <= score_d;
            hi_q     <= hi_d;
            new_hi_q <= new_hi_d;
        end
    end

    assign score_bcd = score_q;
    assign hi_bcd    = hi_q;
    assign new_hi    = new_hi_q;

    // ------------------------------------------------------------------
    // Display addressing (combinational from x/y)
    // ------------------------------------------------------------------
    logic             in_win;
    logic [9:0]       dx;
    logic [9:0]       slot;
    logic [COL_W-1:0] col;
    logic [DY_W-1:0]  dy_cell;
    logic [SW-1:0]    disp;
    logic [3:0]       dig;
    logic             blank;
    logic [ROW_W-1:0] rom_row;
    logic [COL_W-1:0] rom_col;

    assign in_win = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                    ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);

    assign dx      = x - X_LO[9:0];
    assign dy_cell = DY_W'(y - Y_LO[9:0]);
    assign slot    = W_POW2 ? (dx >> COL_W) : (dx / DW10);
    assign col     = COL_W'(W_POW2 ? (dx & (DW10 - 10'd1)) : (dx % DW10));

    // Slot 0 is the leftmost (most-significant) digit. A slot is blanked
    // when it and every digit to its left are zero; the rightmost slot
    // always shows so a zero value still renders as "0".
    always_comb begin : p_digit_sel
        logic seen_nz;
        disp    = show_hi ? hi_q : score_q;
        dig     = '0;
        blank   = 1'b0;
        seen_nz = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seen_nz = seen_nz | (disp[4*(NUM_DIGITS-1-k) +: 4] != 4'd0);
            if (slot == 10'(k)) begin
                dig   = disp[4*(NUM_DIGITS-1-k) +: 4];
                blank = (LZ_BLANK != 0) && (k != NUM_DIGITS - 1) && !seen_nz;
            end
        end
    end

    assign rom_row = in_win ? (ROW_W'(dy_cell) + ROW_W'(dig) * DH_R) : '0;
    assign rom_col = in_win ? col : '0;

    // ------------------------------------------------------------------
    // numbers_rom: glyph bit for (row, col), registered output.
    // Row r of glyph g lives at row g*DIGIT_H + r.
    // ------------------------------------------------------------------
    int         rom_glyph, rom_r, rom_c;
    logic [6:0] seg_mask;   // {a,b,c,d,e,f,g}
    logic       hbar, vleft, vright, vup, vlo;
    logic       rom_d, rom_q;

    always_comb begin : p_numbers_rom
        rom_glyph = int'(rom_row) / DIGIT_H;
        rom_r     = int'(rom_row) % DIGIT_H;
        rom_c     = int'(rom_col);
        case (rom_glyph)
            0:       seg_mask = 7'b1111110;
            1:       seg_mask = 7'b0110000;
            2:       seg_mask = 7'b1101101;
            3:       seg_mask = 7'b1111001;
            4:       seg_mask = 7'b0110011;
            5:       seg_mask = 7'b1011011;
            6:       seg_mask = 7'b1011111;
            7:       seg_mask = 7'b1110000;
            8:       seg_mask = 7'b1111111;
            9:       seg_mask = 7'b1111011;
            default: seg_mask = 7'b0000000;
        endcase
        hbar   = (rom_c >= SEG_L0) && (rom_c <= SEG_R1);
        vleft  = (rom_c >= SEG_L0) && (rom_c <= SEG_L1);
        vright = (rom_c >= SEG_R0) && (rom_c <= SEG_R1);
        vup    = (rom_r >= SEG_T0) && (rom_r <= SEG_M1);
        vlo    = (rom_r >= SEG_M0) && (rom_r <= SEG_B1);
        rom_d  = (seg_mask[6] && hbar && (rom_r >= SEG_T0) && (rom_r <= SEG_T1)) ||
                 (seg_mask[5] && vright && vup) ||
                 (seg_mask[4] && vright && vlo) ||
                 (seg_mask[3] && hbar && (rom_r >= SEG_B0) && (rom_r <= SEG_B1)) ||
                 (seg_mask[2] && vleft && vlo) ||
                 (seg_mask[1] && vleft && vup) ||
                 (seg_mask[0] && hbar && (rom_r >= SEG_M0) && (rom_r <= SEG_M1));
    end

    // ------------------------------------------------------------------
    // Output pipeline: ROM bit and window/blank flags share one stage, so
    // all three describe the same x/y when combined.
    // ------------------------------------------------------------------
    logic win_q, blank_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_q   <= 1'b0;
            win_q   <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            rom_q   <= rom_d;
            win_q   <= in_win;
            blank_q <= blank;
        end
    end

    assign score_on = rom_q & win_q & ~blank_q;

endmodule

// File: doc/score_display_n.md
Name: score_display_n

Overview:
- Parametrised successor of the fixed 4-digit score overlay.
- Keeps an N-digit BCD score, updated directly in BCD with no binary-to-BCD converter, plus a high-score register.
- Renders either value on the VGA pixel stream through the synchronous numbers_rom, with optional leading-zero blanking.
- Sits beside the other pixel-generation units; score_on feeds the top-level RGB multiplexer.

Parameters:
- NUM_DIGITS, 4: number of decimal digits displayed and stored (1..8).
- X_LEFT, 288: x of the left edge of the most-significant digit.
- Y_TOP, 16: y of the top edge of the digit row.
- DIGIT_W, 16: digit cell width in pixels; matches the numbers_rom column count.
- DIGIT_H, 16: digit cell height in pixels; the numbers_rom row stride per glyph.
- INC, 10: points added per enemy_hit rising edge (decimal, 1..99).
- LZ_BLANK, 1: 1 = suppress leading zeros (least-significant digit always shown); 0 = show all digits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- x  in  10  VGA pixel x
- y  in  10  VGA pixel y
- enemy_hit  in  1  level; each rising edge scores INC points
- score_clr  in  1  synchronous clear of the current score (new game)
- game_over  in  1  single-cycle pulse; commit score to high score if greater
- show_hi  in  1  0 = display current score, 1 = display high score
- score_bcd  out  4*NUM_DIGITS  current score, digit 0 in bits [3:0]
- hi_bcd  out  4*NUM_DIGITS  high score, same packing
- new_hi  out  1  set when the last game_over raised the high score
- score_on  out  1  pixel is a lit glyph pixel; 1-cycle latency versus x/y

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, including score_bcd, hi_bcd, new_hi, score_on, the edge-detect register and the pipeline registers.
- Edge detect: hit_pulse = enemy_hit & ~enemy_hit_q. A held-high enemy_hit scores once.
- Score update, priority order each cycle:
  - score_clr=1: score <= 0; any hit_pulse that cycle is discarded.
  - else hit_pulse: score <= score + INC.
    - Computed as a one-cycle BCD ripple add: digit sum > 9 gives digit - 10 and carry 1.
    - INC is split into tens and units BCD digits at elaboration.
    - Saturation: if the carry leaves digit NUM_DIGITS-1, score <= all 9s (e.g. 9999). It never wraps.
  - else score holds.
- High score: on game_over, if score_reg > hi_reg (unsigned BCD compare, MSD first), then hi <= score_reg and new_hi <= 1; otherwise new_hi <= 0 and hi holds.
  - The compare uses the pre-update score_reg.
  - A hit or clear in the same cycle still updates score normally.
- new_hi is also cleared by score_clr, unless game_over is asserted in the same cycle.
- hi is cleared only by reset.
- Display window: Y_TOP <= y < Y_TOP+DIGIT_H and X_LEFT <= x < X_LEFT+NUM_DIGITS*DIGIT_W.
  - Digit slot k = (x - X_LEFT)/DIGIT_W, counted from the left; slot 0 shows the most-significant digit.
  - Shifts are used when DIGIT_W is a power of 2.
- ROM addressing, combinational from x/y:
  - col = (x - X_LEFT) mod DIGIT_W
  - row = (y - Y_TOP) + d*DIGIT_H, where d is the selected digit value (score or hi per show_hi)
  - Outside the window, row = col = 0.
- Pipeline:
  - numbers_rom output is registered, 1 cycle.
  - In-window, blank-slot and valid flags are registered alongside it.
  - score_on = rom_bit & win_q & ~blank_q.
  - Total latency from x/y to score_on is exactly 1 clk.
- Leading-zero blank (LZ_BLANK=1): a slot is blank if it and every more-significant digit are 0; the last slot is never blank.
  - Score 0040 shows "40", right-aligned in fixed slots.
- show_hi and the score may change mid-frame; the glyph reflects the values sampled in the cycle x/y is presented. No tearing protection is required.
- Reset mid-frame: score_on drops immediately and asynchronously; rendering resumes on the first x/y after release, with score 0.

Test Plan:
- Reset, then one enemy_hit rising edge with INC=10 -> score_bcd=0x0010 one cycle after the edge; enemy_hit held high 50 cycles -> still 0x0010.
- Preload 9990 via 999 hits, then 2 more hits -> 9999 after the first, still 9999 after the second (saturates, no wrap); hit 0x0095+INC=10 -> 0x0105 (BCD carry across two digits).
- Score 0120, game_over -> hi_bcd=0x0120, new_hi=1; score_clr -> score 0, new_hi=0, hi holds; score 0050, game_over -> hi stays 0x0120, new_hi=0.
- score_clr and hit_pulse in the same cycle -> score 0; game_over and hit in the same cycle at score 0030, hi 0 -> hi=0x0030, score=0x0040.
- Score 0040, LZ_BLANK=1, scan y=20 across x=288..351 -> score_on is 0 for x<320; score_on matches the "4" and "0" glyph bits for x=320..351, each sample delayed one clk; score_on=0 for y=15 and y=32.
- NUM_DIGITS=6, X_LEFT=100, show_hi toggled -> window spans x=100..195, and the glyph source switches between score and hi within one clk.
